// File: rtl/ann_pkg.sv
// Shared constants and helpers for the ANN input path.
package ann_pkg;

    localparam int unsigned BIT_ORDER_MSB = 1;
    localparam int unsigned BIT_ORDER_LSB = 0;

    // Index width for a range of v values; never less than one bit.
    function automatic int unsigned clog2_min1(input int unsigned v);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < v) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/param_deserializer_if.sv
// Serial input and word output handshake of the deserializer.
interface param_deserializer_if #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned FILL_W = $clog2(FIFO_DEPTH) + 1;

    logic              ser_in;
    logic              ser_valid;
    logic              frame_start;
    logic [DATA_W-1:0] data_out;
    logic              out_valid;
    logic              out_ready;
    logic [FILL_W-1:0] fill_level;
    logic              overflow;
    logic              clear_ovf;

    modport master (
        output ser_in, ser_valid, frame_start, out_ready, clear_ovf,
        input  data_out, out_valid, fill_level, overflow
    );

    modport slave (
        input  ser_in, ser_valid, frame_start, out_ready, clear_ovf,
        output data_out, out_valid, fill_level, overflow
    );

endinterface

// File: rtl/param_deserializer_sync_fifo.sv
// Show-ahead synchronous FIFO; a push while full is only taken alongside a pop.
module sync_fifo
    import ann_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               wdata,
    output logic [WIDTH-1:0]               rdata,
    output logic                           full,
    output logic                           empty,
    output logic [clog2_min1(DEPTH):0]     count
);
    localparam int unsigned PTR_W = clog2_min1(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count_next;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            count <= count_next;
            full  <= (count_next == CNT_W'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/param_deserializer.sv
// Serial-to-parallel word assembler feeding a show-ahead output FIFO.
module param_deserializer
    import ann_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MSB_FIRST  = BIT_ORDER_MSB
) (
    input  logic                 clk,
    input  logic                 reset,
    param_deserializer_if.slave  bus
);
    localparam int unsigned CNT_W  = clog2_min1(DATA_W);
    localparam int unsigned FILL_W = clog2_min1(FIFO_DEPTH) + 1;

    logic [DATA_W-1:0] sr;
    logic [DATA_W-1:0] word_next;
    logic [DATA_W-1:0] word_first;
    logic [CNT_W-1:0]  bit_cnt;
    logic              word_last;
    logic              push;
    logic              pop;
    logic              drop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FILL_W-1:0] fifo_count;
    logic              overflow_q;

    // word_first is the shift result when frame_start discards the partial word.
    if (MSB_FIRST == BIT_ORDER_MSB) begin : g_msb
        assign word_next  = {sr[DATA_W-2:0], bus.ser_in};
        assign word_first = {{(DATA_W-1){1'b0}}, bus.ser_in};
    end else begin : g_lsb
        assign word_next  = {bus.ser_in, sr[DATA_W-1:1]};
        assign word_first = {bus.ser_in, {(DATA_W-1){1'b0}}};
    end

    assign word_last = (bit_cnt == CNT_W'(DATA_W - 1));
    assign push      = bus.ser_valid & ~bus.frame_start & word_last & ~reset;
    assign pop       = bus.out_ready & ~fifo_empty;
    assign drop      = push & fifo_full & ~pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else if (bus.ser_valid) begin
            if (bus.frame_start) begin
                sr      <= word_first;
                bit_cnt <= CNT_W'(1);
            end else begin
                sr      <= word_next;
                bit_cnt <= word_last ? '0 : bit_cnt + CNT_W'(1);
            end
        end else if (bus.frame_start) begin
            sr      <= '0;
            bit_cnt <= '0;
        end
    end

    // Sticky drop flag; a new drop outranks the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end else if (bus.clear_ovf) begin
            overflow_q <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (word_next),
        .rdata (bus.data_out),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bus.out_valid  = ~fifo_empty;
    assign bus.fill_level = fifo_count;
    assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_param_deserializer.sv
// Directed and random bench for both bit orders against a queue-based reference.
module tb_param_deserializer;
    import ann_pkg::*;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ser_in = 1'b0;
    logic ser_valid = 1'b0;
    logic frame_start = 1'b0;
    logic out_ready = 1'b0;
    logic clear_ovf = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    bit         bq[$];
    logic [7:0] fq[$];
    bit         m_ovf = 1'b0;

    always #5 clk = ~clk;

    param_deserializer_if #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) if_m ();
    param_deserializer_if #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) if_l ();

    assign if_m.ser_in      = ser_in;
    assign if_m.ser_valid   = ser_valid;
    assign if_m.frame_start = frame_start;
    assign if_m.out_ready   = out_ready;
    assign if_m.clear_ovf   = clear_ovf;
    assign if_l.ser_in      = ser_in;
    assign if_l.ser_valid   = ser_valid;
    assign if_l.frame_start = frame_start;
    assign if_l.out_ready   = out_ready;
    assign if_l.clear_ovf   = clear_ovf;

    param_deserializer #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .MSB_FIRST(BIT_ORDER_MSB)) u_msb (
        .clk   (clk),
        .reset (reset),
        .bus   (if_m)
    );

    param_deserializer #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .MSB_FIRST(BIT_ORDER_LSB)) u_lsb (
        .clk   (clk),
        .reset (reset),
        .bus   (if_l)
    );

    function automatic logic [7:0] rev8(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = w[7-i];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: bits collect in arrival order; words are stored first-bit-in-MSB.
    task automatic model_edge();
        bit         pop;
        bit         push;
        bit         drop;
        logic [7:0] w;
        w    = '0;
        push = 1'b0;
        if (reset) begin
            bq.delete();
            fq.delete();
            m_ovf = 1'b0;
        end else begin
            pop = (fq.size() != 0) && out_ready;
            if (ser_valid) begin
                if (frame_start) bq.delete();
                bq.push_back(ser_in);
                if (bq.size() == DW) begin
                    push = 1'b1;
                    for (int i = 0; i < DW; i++) w[DW-1-i] = bq[i];
                    bq.delete();
                end
            end else if (frame_start) begin
                bq.delete();
            end
            drop = push && (fq.size() == DEPTH) && !pop;
            if (pop) void'(fq.pop_front());
            if (push && !drop) fq.push_back(w);
            if (drop) m_ovf = 1'b1;
            else if (clear_ovf) m_ovf = 1'b0;
        end
    endtask

    task automatic check_all();
        logic [7:0] head;
        head = (fq.size() != 0) ? fq[0] : 8'h00;
        check("msb_data_out",   32'(if_m.data_out),   32'(head));
        check("msb_out_valid",  32'(if_m.out_valid),  32'(fq.size() != 0));
        check("msb_fill_level", 32'(if_m.fill_level), 32'(fq.size()));
        check("msb_overflow",   32'(if_m.overflow),   32'(m_ovf));
        check("lsb_data_out",   32'(if_l.data_out),   32'(rev8(head)));
        check("lsb_out_valid",  32'(if_l.out_valid),  32'(fq.size() != 0));
        check("lsb_fill_level", 32'(if_l.fill_level), 32'(fq.size()));
        check("lsb_overflow",   32'(if_l.overflow),   32'(m_ovf));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic send_bit(input logic b, input logic fs);
        ser_valid   = 1'b1;
        ser_in      = b;
        frame_start = fs;
        cycle();
        ser_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) send_bit(w[i], 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        logic [7:0] w;

        reset = 1'b1;
        cycle();
        check("reset_valid", 32'(if_m.out_valid), 32'd0);
        check("reset_fill",  32'(if_m.fill_level), 32'd0);
        reset = 1'b0;
        idle(2);

        // 1: A5 with gaps, drained immediately
        out_ready = 1'b1;
        w = 8'hA5;
        for (int i = 7; i >= 0; i--) begin
            send_bit(w[i], 1'b0);
            if (i != 0) cycle();
        end
        check("t1_word",  32'(if_m.data_out), 32'hA5);
        check("t1_valid", 32'(if_m.out_valid), 32'd1);
        cycle();
        check("t1_valid_drop", 32'(if_m.out_valid), 32'd0);
        check("t1_fill",       32'(if_m.fill_level), 32'd0);

        // 2: bit order
        w = 8'hC0;
        for (int i = 7; i >= 0; i--) send_bit(w[i], 1'b0);
        check("t2_msb", 32'(if_m.data_out), 32'hC0);
        check("t2_lsb", 32'(if_l.data_out), 32'h03);
        idle(2);

        // 3: realign discards three leading bits
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b1);
        for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0);
        check("t3_word", 32'(if_m.data_out), 32'hFF);
        check("t3_fill", 32'(if_m.fill_level), 32'd1);
        out_ready = 1'b1;
        idle(2);
        check("t3_empty", 32'(if_m.out_valid), 32'd0);

        // 4: overflow with stalled consumer
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            send_word(8'(k));
            if (k == 4) check("t4_fill4", 32'(if_m.fill_level), 32'd4);
        end
        check("t4_ovf", 32'(if_m.overflow), 32'd1);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check("t4_pop", 32'(if_m.data_out), 32'(k));
            cycle();
        end
        check("t4_drained", 32'(if_m.out_valid), 32'd0);
        check("t4_ovf_held", 32'(if_m.overflow), 32'd1);
        clear_ovf = 1'b1;
        cycle();
        clear_ovf = 1'b0;
        check("t4_ovf_clr", 32'(if_m.overflow), 32'd0);

        // 5: full FIFO with push and pop on the same edge
        out_ready = 1'b0;
        for (int k = 8'h10; k <= 8'h13; k++) send_word(8'(k));
        w = 8'h14;
        for (int i = 7; i >= 1; i--) send_bit(w[i], 1'b0);
        out_ready = 1'b1;
        send_bit(w[0], 1'b0);
        check("t5_ovf",  32'(if_m.overflow), 32'd0);
        check("t5_fill", 32'(if_m.fill_level), 32'd4);
        for (int k = 8'h11; k <= 8'h14; k++) begin
            check("t5_order", 32'(if_m.data_out), 32'(k));
            cycle();
        end

        // 6: reset mid-word
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        reset = 1'b1;
        cycle();
        check("t6_rst_data",  32'(if_m.data_out), 32'd0);
        check("t6_rst_valid", 32'(if_m.out_valid), 32'd0);
        check("t6_rst_fill",  32'(if_m.fill_level), 32'd0);
        check("t6_rst_ovf",   32'(if_m.overflow), 32'd0);
        reset = 1'b0;
        send_word(8'h3C);
        check("t6_word", 32'(if_m.data_out), 32'h3C);
        check("t6_fill", 32'(if_m.fill_level), 32'd1);
        out_ready = 1'b1;
        idle(2);

        // Random traffic against the reference
        for (int n = 0; n < 3000; n++) begin
            ser_valid   = ($urandom_range(0, 9) < 7);
            ser_in      = 1'($urandom);
            frame_start = ($urandom_range(0, 99) < 5);
            out_ready   = ($urandom_range(0, 9) < 4);
            clear_ovf   = ($urandom_range(0, 99) < 3);
            reset       = ($urandom_range(0, 999) < 3);
            cycle();
        end
        ser_valid   = 1'b0;
        frame_start = 1'b0;
        clear_ovf   = 1'b0;
        reset       = 1'b0;
        out_ready   = 1'b1;
        idle(6);
        check("final_empty", 32'(if_m.fill_level), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/param_deserializer.md
Name: param_deserializer

Overview:
Parametrised serial-to-parallel converter for the ANN input path. Bits arrive on a strobed serial line and are assembled into DATA_W-bit words, MSB-first or LSB-first. A frame_start input realigns word boundaries. Completed words are buffered in a small show-ahead FIFO and leave through a valid/ready handshake, so a stalled consumer does not lose data until the FIFO fills.

Parameters:
DATA_W, 8, word width in bits; legal range is 2 or more.
FIFO_DEPTH, 4, output FIFO entries; must be a power of 2 and at least 2.
MSB_FIRST, 1, 1 means the first received bit becomes word bit DATA_W-1; 0 means the first received bit becomes word bit 0.

Ports:
clk  in  1  clock; all logic is on the rising edge.
reset  in  1  synchronous, active-high reset.
ser_in  in  1  serial data bit.
ser_valid  in  1  ser_in is sampled only on cycles where ser_valid=1.
frame_start  in  1  the current position is a word boundary; any partial word is discarded.
data_out  out  DATA_W  head-of-FIFO word.
out_valid  out  1  FIFO is non-empty.
out_ready  in  1  consumer accepts data_out when out_valid=1.
fill_level  out  $clog2(FIFO_DEPTH)+1  number of words held in the FIFO.
overflow  out  1  sticky flag: a completed word was dropped.
clear_ovf  in  1  clears overflow.

Behaviour:
- Reset (clk edge with reset=1):
  - shift register and bit_cnt go to 0.
  - FIFO is emptied.
  - data_out=0, out_valid=0, fill_level=0, overflow=0.
  - A partial word is lost. No word is pushed on the reset cycle.
- Bit assembly, on a cycle with ser_valid=1:
  - MSB_FIRST=1: word_next = {sr[DATA_W-2:0], ser_in}.
  - MSB_FIRST=0: word_next = {ser_in, sr[DATA_W-1:1]}.
  - bit_cnt increments.
- Word completion:
  - Occurs when ser_valid=1 and bit_cnt==DATA_W-1.
  - word_next, which includes the current bit, is pushed to the FIFO on that edge, and bit_cnt wraps to 0.
- Idle cycles: ser_valid=0 holds sr and bit_cnt. Gaps of any length between bits are legal.
- frame_start=1 with ser_valid=0: bit_cnt goes to 0 and sr goes to 0. Nothing is pushed.
- frame_start=1 with ser_valid=1: the partial word is discarded and the current bit is taken as bit #0 of a new word (bit_cnt goes to 1).
- frame_start=1 on the same cycle as an otherwise-completing bit: frame_start wins. Nothing is pushed and the bit starts a new word.
- Latency: if the FIFO was empty, a pushed word appears on data_out with out_valid=1 on the cycle after the completing strobe.
- FIFO (show-ahead):
  - data_out always shows the oldest entry. It is 0 when empty.
  - Pop occurs when out_valid & out_ready.
  - out_ready while empty has no effect.
  - Push and pop on the same cycle leave fill_level unchanged.
  - If full with a pop on the same cycle, the push is accepted.
  - Pointers wrap modulo FIFO_DEPTH.
- Overflow:
  - A push while full with no pop drops the new word. FIFO contents are unchanged and overflow is set to 1 on the next edge.
  - overflow stays at 1 until clear_ovf=1.
  - If clear_ovf and a new drop occur on the same cycle, overflow stays 1 (set wins).
- The block has no FSM beyond bit_cnt and the FIFO pointers. All outputs are registered, except data_out, which is read combinationally from the FIFO storage at the registered read pointer.

Decomposition:
- ann_pkg holds two constants:
  - BIT_ORDER_MSB=1 and BIT_ORDER_LSB=0, used as MSB_FIRST values.
  - Helper function clog2_min1 (returns 1 or more), used for pointer widths.
- One sub-module, sync_fifo:
  - Parameters: WIDTH and DEPTH.
  - Behaviour: show-ahead, with push, pop, full, empty and count.
  - A push while full is ignored unless a pop occurs on the same cycle.
  - The overflow flag lives in param_deserializer, not in the FIFO.

Test Plan:
1. MSB_FIRST=1, out_ready=1, bits 1,0,1,0,0,1,0,1 with one idle cycle between each bit. Required: data_out=8'hA5 with out_valid=1 for exactly 1 cycle, one cycle after the 8th strobe, and fill_level returns to 0.
2. Bit order: bits 1,1,0,0,0,0,0,0 on back-to-back strobes. Required: MSB_FIRST=1 gives 8'hC0; MSB_FIRST=0 gives 8'h03.
3. Realign: 3 strobes of 0, then frame_start=1 with ser_valid=1 and ser_in=1, then 7 more strobes of 1. Required: exactly one word, 8'hFF, and no word is produced from the discarded 3 bits.
4. Overflow: out_ready=0, 5 words 8'h01 to 8'h05. Required:
   - fill_level=4 after the 4th word.
   - overflow=1 the cycle after the 5th word completes.
   - Then out_ready=1 pops 01, 02, 03, 04 and out_valid drops.
   - clear_ovf=1 clears overflow.
5. Full with simultaneous push and pop: fill the FIFO to 4 entries, then complete a 5th word on a cycle with out_ready=1. Required: no overflow, fill_level stays at 4, and the output order is preserved.
6. Reset mid-word: 5 bits sent, reset pulsed for 1 cycle, then a full word 8'h3C. Required: the only output is 8'h3C; all outputs read 0 during reset; fill_level=0.
